// File: rtl/knn_insert_sorter_if.sv
// Sample stream into the K-nearest selector: one (distance, label) pair per
// accepted valid/ready handshake. The distance datapath is the master.
interface knn_insert_sorter_if #(
  parameter int DIST_W  = 32,
  parameter int LABEL_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [DIST_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;

  modport master (
    output in_valid,
    output in_dist,
    output in_label,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_dist,
    input  in_label,
    output in_ready
  );
endinterface

// File: rtl/knn_insert_sorter.sv
// knn_insert_sorter: streaming K-nearest selector. Keeps the K smallest
// distances in ascending order in a register insertion array, and can
// optionally run a majority vote over the retained neighbours.
//
// Optional feature macro: KNN_VOTE_EN (builds the vote FSM, scan counter,
// label comparators and vote result registers). Without it the block is a
// pure insertion sorter with the vote outputs tied off.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | accepting samples (in_ready=1), waiting for vote_start
// S_VOTE | scanning slot j = 0..K-1 (in_ready=0, busy=1)
module knn_insert_sorter #(
  parameter int K       = 10,
  parameter int DIST_W  = 32,
  parameter int LABEL_W = 8,
  parameter int IDX_W   = $clog2(K),
  parameter int CNT_W   = $clog2(K + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  knn_insert_sorter_if.slave  in_if,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [DIST_W-1:0]   rd_dist,
  output logic [LABEL_W-1:0]  rd_label,
  output logic [CNT_W-1:0]    count,
  input  logic                vote_start,
  output logic                busy,
  output logic                vote_valid,
  output logic [LABEL_W-1:0]  vote_label,
  output logic [CNT_W-1:0]    vote_count
);

  logic [K-1:0]       slot_valid;
  logic [DIST_W-1:0]  slot_dist  [K];
  logic [LABEL_W-1:0] slot_label [K];

  // ins_before[i]: the new sample belongs at or before slot i. The array is
  // sorted with empty slots at the tail, so this vector is monotonic and the
  // insertion point is its first set bit.
  logic [K-1:0]       ins_before;
  logic               accept;

  assign accept = in_if.in_valid && in_if.in_ready && !clear;

  // Strict less-than keeps equal distances in arrival order
  always_comb begin
    ins_before = '0;
    for (int i = 0; i < K; i++) begin
      ins_before[i] = !slot_valid[i] || (in_if.in_dist < slot_dist[i]);
    end
  end

  // Insertion array: shift-and-insert on accept, soft clear empties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int i = 0; i < K; i++) begin
        slot_dist[i]  <= '1;
        slot_label[i] <= '0;
      end
      count <= '0;
    end else if (clear) begin
      slot_valid <= '0;
      count      <= '0;
    end else if (accept) begin
      if (ins_before[0]) begin
        slot_valid[0] <= 1'b1;
        slot_dist[0]  <= in_if.in_dist;
        slot_label[0] <= in_if.in_label;
      end
      for (int i = 1; i < K; i++) begin
        if (ins_before[i] && !ins_before[i-1]) begin
          slot_valid[i] <= 1'b1;
          slot_dist[i]  <= in_if.in_dist;
          slot_label[i] <= in_if.in_label;
        end else if (ins_before[i]) begin
          slot_valid[i] <= slot_valid[i-1];
          slot_dist[i]  <= slot_dist[i-1];
          slot_label[i] <= slot_label[i-1];
        end
      end
      if (count != CNT_W'(K)) begin
        count <= count + 1'b1;
      end
    end
  end

  // Slot readback; indices beyond the array read as empty with zero data
  always_comb begin
    rd_valid = 1'b0;
    rd_dist  = '0;
    rd_label = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_valid = slot_valid[i];
        rd_dist  = slot_dist[i];
        rd_label = slot_label[i];
      end
    end
  end

`ifdef KNN_VOTE_EN

  localparam int SCAN_W = $clog2(K);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_VOTE = 1'b1
  } state_t;

  state_t             state;
  logic [SCAN_W-1:0]  scan_j;
  logic [CNT_W-1:0]   best_m;
  logic [LABEL_W-1:0] best_label;

  logic               cur_valid;
  logic [LABEL_W-1:0] cur_label;
  logic [CNT_W-1:0]   cur_m;
  logic               take;

  // Occurrence count of the scanned slot's label across all valid slots;
  // only a strictly larger count displaces the best, so nearer slots win ties
  always_comb begin
    cur_valid = 1'b0;
    cur_label = '0;
    cur_m     = '0;
    for (int i = 0; i < K; i++) begin
      if (scan_j == SCAN_W'(i)) begin
        cur_valid = slot_valid[i];
        cur_label = slot_label[i];
      end
    end
    for (int i = 0; i < K; i++) begin
      cur_m = cur_m + CNT_W'(slot_valid[i] && (slot_label[i] == cur_label));
    end
    take = cur_valid && (cur_m > best_m);
  end

  // Vote FSM: one slot per cycle, result registered on the last scan cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      scan_j     <= '0;
      best_m     <= '0;
      best_label <= '0;
      vote_valid <= 1'b0;
      vote_label <= '0;
      vote_count <= '0;
    end else begin
      vote_valid <= 1'b0;
      if (clear) begin
        state  <= S_IDLE;
        scan_j <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (vote_start) begin
              state      <= S_VOTE;
              scan_j     <= '0;
              best_m     <= '0;
              best_label <= '0;
            end
          end
          S_VOTE: begin
            if (take) begin
              best_m     <= cur_m;
              best_label <= cur_label;
            end
            if (scan_j == SCAN_W'(K - 1)) begin
              state      <= S_IDLE;
              vote_valid <= 1'b1;
              vote_label <= take ? cur_label : best_label;
              vote_count <= take ? cur_m : best_m;
            end else begin
              scan_j <= scan_j + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_if.in_ready = (state == S_IDLE);
  assign busy           = (state == S_VOTE);

`else

  logic unused_vote_start;

  assign unused_vote_start = vote_start;
  assign in_if.in_ready    = 1'b1;
  assign busy              = 1'b0;
  assign vote_valid        = 1'b0;
  assign vote_label        = '0;
  assign vote_count        = '0;

`endif

endmodule

// File: tb/tb_knn_insert_sorter.sv
// Scoreboard bench for knn_insert_sorter (K=4, DIST_W=8, LABEL_W=4).
// Stimulus pushes expected readbacks and vote results into queues; a
// negedge monitor pops and compares whenever a readback is strobed or
// vote_valid is presented.
module tb_knn_insert_sorter;

  localparam int K       = 4;
  localparam int DIST_W  = 8;
  localparam int LABEL_W = 4;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 3;
`ifdef KNN_VOTE_EN
  localparam bit VOTE_EN = 1'b1;
`else
  localparam bit VOTE_EN = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic [DIST_W-1:0]  rd_dist;
  logic [LABEL_W-1:0] rd_label;
  logic [CNT_W-1:0]   count;
  logic               vote_start;
  logic               busy;
  logic               vote_valid;
  logic [LABEL_W-1:0] vote_label;
  logic [CNT_W-1:0]   vote_count;

  knn_insert_sorter_if #(.DIST_W(DIST_W), .LABEL_W(LABEL_W)) sorter_if ();

  knn_insert_sorter #(
    .K(K), .DIST_W(DIST_W), .LABEL_W(LABEL_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_if      (sorter_if.slave),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_dist    (rd_dist),
    .rd_label   (rd_label),
    .count      (count),
    .vote_start (vote_start),
    .busy       (busy),
    .vote_valid (vote_valid),
    .vote_label (vote_label),
    .vote_count (vote_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0]   idx;
    logic               v;
    logic               data;
    logic [DIST_W-1:0]  d;
    logic [LABEL_W-1:0] l;
    logic [CNT_W-1:0]   cnt;
    logic               bsy;
    logic               rdy;
    logic [LABEL_W-1:0] vl;
    logic [CNT_W-1:0]   vc;
  } rd_exp_t;

  typedef struct {
    logic [LABEL_W-1:0] l;
    logic [CNT_W-1:0]   c;
    int                 cyc;
  } vote_exp_t;

  rd_exp_t   rd_q[$];
  vote_exp_t vote_q[$];
  logic      rd_chk;
  int        cyc;
  int        checks;
  int        errors;
  logic [LABEL_W-1:0] cur_vl;
  logic [CNT_W-1:0]   cur_vc;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare strobed readbacks and every vote_valid pulse
  always @(negedge clk) begin
    rd_exp_t   e;
    vote_exp_t ve;
    if (rd_chk) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: readback strobed with no expectation");
      end else begin
        e = rd_q.pop_front();
        if (rd_valid !== e.v || count !== e.cnt || busy !== e.bsy ||
            sorter_if.in_ready !== e.rdy || vote_label !== e.vl ||
            vote_count !== e.vc ||
            (e.data && (rd_dist !== e.d || rd_label !== e.l))) begin
          errors++;
          $display("FAIL rd_slot%0d t=%0t got v=%b d=%0d l=%0d cnt=%0d busy=%b rdy=%b vl=%0d vc=%0d, want v=%b d=%0d l=%0d cnt=%0d busy=%b rdy=%b vl=%0d vc=%0d",
                   e.idx, $time, rd_valid, rd_dist, rd_label, count, busy,
                   sorter_if.in_ready, vote_label, vote_count, e.v, e.d, e.l,
                   e.cnt, e.bsy, e.rdy, e.vl, e.vc);
        end
      end
    end
    if (vote_valid) begin
      checks++;
      if (vote_q.size() == 0) begin
        errors++;
        $display("FAIL vote_unexpected t=%0t got label=%0d count=%0d, want no vote_valid",
                 $time, vote_label, vote_count);
      end else begin
        ve = vote_q.pop_front();
        if (vote_label !== ve.l || vote_count !== ve.c || cyc != ve.cyc) begin
          errors++;
          $display("FAIL vote_result got label=%0d count=%0d cyc=%0d, want label=%0d count=%0d cyc=%0d",
                   vote_label, vote_count, cyc, ve.l, ve.c, ve.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input int d, input int l);
    sorter_if.in_valid = 1'b1;
    sorter_if.in_dist  = DIST_W'(d);
    sorter_if.in_label = LABEL_W'(l);
    tick();
    sorter_if.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Queue one readback expectation and strobe it for a single cycle
  task automatic chk(input int idx, input logic v, input logic data,
                     input int d, input int l, input int cnt,
                     input logic bsy, input logic rdy);
    rd_exp_t e;
    e.idx  = IDX_W'(idx);
    e.v    = v;
    e.data = data;
    e.d    = DIST_W'(d);
    e.l    = LABEL_W'(l);
    e.cnt  = CNT_W'(cnt);
    e.bsy  = bsy;
    e.rdy  = rdy;
    e.vl   = cur_vl;
    e.vc   = cur_vc;
    rd_q.push_back(e);
    rd_idx = IDX_W'(idx);
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  // Idle-state readback of an occupied slot
  task automatic chk_slot(input int idx, input int d, input int l, input int cnt);
    chk(idx, 1'b1, 1'b1, d, l, cnt, 1'b0, 1'b1);
  endtask

  // vote_start (optionally with a same-cycle insert); result expected K
  // cycles after the sampling edge
  task automatic start_vote(input logic with_ins, input int d, input int l,
                            input int el, input int ec);
    vote_exp_t ve;
    vote_start = 1'b1;
    if (with_ins) begin
      sorter_if.in_valid = 1'b1;
      sorter_if.in_dist  = DIST_W'(d);
      sorter_if.in_label = LABEL_W'(l);
    end
    tick();
    vote_start         = 1'b0;
    sorter_if.in_valid = 1'b0;
    ve.l   = LABEL_W'(el);
    ve.c   = CNT_W'(ec);
    ve.cyc = cyc + K;
    if (VOTE_EN) vote_q.push_back(ve);
  endtask

  // Busy window readbacks of slot 0; optional re-pulse of vote_start
  task automatic busy_window(input int n, input int d0, input int l0,
                             input int cnt, input int restart_at);
    for (int k = 0; k < n; k++) begin
      if (k == restart_at) vote_start = 1'b1;
      chk(0, 1'b1, 1'b1, d0, l0, cnt, VOTE_EN, !VOTE_EN);
      vote_start = 1'b0;
    end
  endtask

  task automatic finish_vote(input int el, input int ec);
    if (VOTE_EN) begin
      cur_vl = LABEL_W'(el);
      cur_vc = CNT_W'(ec);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    cur_vl = '0;
    cur_vc = '0;
    rst_n  = 1'b0;
    clear  = 1'b0;
    rd_idx = '0;
    rd_chk = 1'b0;
    vote_start         = 1'b0;
    sorter_if.in_valid = 1'b0;
    sorter_if.in_dist  = '0;
    sorter_if.in_label = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state: empty slot reads dist all ones, label 0
    chk(0, 1'b0, 1'b1, 255, 0, 0, 1'b0, 1'b1);

    // Back-to-back stream of four samples
    insert(50, 1);
    insert(20, 2);
    insert(80, 3);
    insert(10, 4);
    chk_slot(0, 10, 4, 4);
    chk_slot(1, 20, 2, 4);
    chk_slot(2, 50, 1, 4);
    chk_slot(3, 80, 3, 4);

    // Full array: 30 displaces 80; 90 is discarded
    insert(30, 5);
    chk_slot(2, 30, 5, 4);
    chk_slot(3, 50, 1, 4);
    insert(90, 6);
    chk_slot(3, 50, 1, 4);

    // Equal distance lands after the older equal entry
    insert(20, 7);
    chk_slot(1, 20, 2, 4);
    chk_slot(2, 20, 7, 4);
    chk_slot(3, 30, 5, 4);
    chk(4, 1'b0, 1'b1, 0, 0, 4, 1'b0, 1'b1);
    chk(7, 1'b0, 1'b1, 0, 0, 4, 1'b0, 1'b1);

    // Majority vote over {10/4,20/2,30/2,50/1}
    do_clear();
    chk(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    insert(50, 1);
    insert(30, 2);
    insert(20, 2);
    insert(10, 4);
    chk_slot(2, 30, 2, 4);
    start_vote(1'b0, 0, 0, 2, 2);
    busy_window(K, 10, 4, 4, 2);
    finish_vote(2, 2);
    chk_slot(0, 10, 4, 4);

    // Tie vote with the fourth sample inserted in the vote_start cycle:
    // {1,2,2,1} gives label 1 (nearer wins the 2-2 tie)
    do_clear();
    insert(10, 1);
    insert(20, 2);
    insert(30, 2);
    start_vote(1'b1, 40, 1, 1, 2);
    busy_window(K, 10, 1, 4, -1);
    finish_vote(1, 2);
    chk_slot(3, 40, 1, 4);

    // Clear together with in_valid mid-vote: scan aborted, sample dropped
    start_vote(1'b0, 0, 0, 0, 0);
    if (VOTE_EN) void'(vote_q.pop_back());
    busy_window(2, 10, 1, 4, -1);
    clear = 1'b1;
    sorter_if.in_valid = 1'b1;
    sorter_if.in_dist  = 8'd5;
    sorter_if.in_label = 4'd9;
    tick();
    clear = 1'b0;
    sorter_if.in_valid = 1'b0;
    chk(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    repeat (K + 2) tick();
    chk(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Clear beats a simultaneous insert in idle too
    insert(70, 3);
    clear = 1'b1;
    sorter_if.in_valid = 1'b1;
    sorter_if.in_dist  = 8'd6;
    sorter_if.in_label = 4'd8;
    tick();
    clear = 1'b0;
    sorter_if.in_valid = 1'b0;
    chk(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an insert stream
    insert(60, 3);
    chk_slot(0, 60, 3, 1);
    sorter_if.in_valid = 1'b1;
    sorter_if.in_dist  = 8'd70;
    sorter_if.in_label = 4'd4;
    rst_n  = 1'b0;
    cur_vl = '0;
    cur_vc = '0;
    chk(0, 1'b0, 1'b1, 255, 0, 0, 1'b0, 1'b1);
    sorter_if.in_valid = 1'b0;
    rst_n = 1'b1;
    chk(1, 1'b0, 1'b1, 255, 0, 0, 1'b0, 1'b1);

    // Vote on an empty array still pulses vote_valid with zero result
    start_vote(1'b0, 0, 0, 0, 0);
    for (int k = 0; k < K; k++) begin
      chk(0, 1'b0, 1'b0, 0, 0, 0, VOTE_EN, !VOTE_EN);
    end
    finish_vote(0, 0);
    chk(0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);

    repeat (K + 2) tick();

    // Every pushed expectation must have been consumed
    checks++;
    if (vote_q.size() != 0) begin
      errors++;
      $display("FAIL vote_pending got %0d outstanding results, want 0", vote_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_pending got %0d outstanding readbacks, want 0", rd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
